// File: rtl/prog_timeout_timer.sv
// Programmable timeout timer: a prescaler turns cnt_pulse strobes into base ticks,
// and a loadable down-counter of base ticks expires in one-shot or periodic mode.
`timescale 1ns/1ps
module prog_timeout_timer #(
  parameter int unsigned PRESCALE = 50,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cnt_en,
  input  logic             cnt_pulse,
  input  logic [CNT_W-1:0] load_val,
  input  logic             periodic,
  input  logic             restart,
  output logic             tick,
  output logic             timeout,
  output logic             expired,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             expired_q, expired_d;
  logic             periodic_q, periodic_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] reload_val;

  // A load of zero would otherwise never expire, so it behaves as a single tick.
  assign reload_val = (load_val == '0) ? CNT_W'(1) : load_val;
  assign tick       = (state_q == RUN) && cnt_pulse && (pre_cnt_q == PRE_MAX);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      pre_cnt_q   <= '0;
      remaining_q <= '0;
      expired_q   <= 1'b0;
      periodic_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      remaining_q <= remaining_d;
      expired_q   <= expired_d;
      periodic_q  <= periodic_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    remaining_d = remaining_q;
    expired_d   = expired_q;
    periodic_d  = periodic_q;
    timeout_d   = 1'b0;

    if (!cnt_en) begin
      state_d     = IDLE;
      pre_cnt_d   = '0;
      remaining_d = '0;
      expired_d   = 1'b0;
      periodic_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d     = RUN;
          pre_cnt_d   = '0;
          remaining_d = reload_val;
          periodic_d  = periodic;
          expired_d   = 1'b0;
        end
        RUN: begin
          // Restart wins over a coincident tick, so it also swallows an expiry.
          if (restart) begin
            pre_cnt_d   = '0;
            remaining_d = reload_val;
            periodic_d  = periodic;
          end else if (tick) begin
            pre_cnt_d = '0;
            if (remaining_q <= CNT_W'(1)) begin
              timeout_d = 1'b1;
              if (periodic_q) begin
                remaining_d = reload_val;
              end else begin
                remaining_d = '0;
                expired_d   = 1'b1;
                state_d     = DONE;
              end
            end else begin
              remaining_d = remaining_q - CNT_W'(1);
            end
          end else if (cnt_pulse) begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
          end
        end
        DONE: begin
          if (restart) begin
            state_d     = RUN;
            pre_cnt_d   = '0;
            remaining_d = reload_val;
            periodic_d  = periodic;
            expired_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy      = (state_q == RUN);
  assign timeout   = timeout_q;
  assign expired   = expired_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_prog_timeout_timer.sv
// Bench for prog_timeout_timer: directed scenarios plus random traffic against a
// strobe-counting reference model, and a PRESCALE=1 full-range counter instance.
`timescale 1ns/1ps
module tb_prog_timeout_timer;
  localparam int P  = 4;
  localparam int W  = 6;
  localparam int WB = 4;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic cnt_en = 1'b0, cnt_pulse = 1'b0, periodic = 1'b0, restart = 1'b0;
  logic [W-1:0] load_val = '0;
  logic tick, timeout, expired, busy;
  logic [W-1:0] remaining;

  logic enB = 1'b0, pulseB = 1'b0;
  logic [WB-1:0] loadB = '0;
  logic tickB, timeoutB, expiredB, busyB;
  logic [WB-1:0] remainingB;

  int checks = 0;
  int errors = 0;

  // Model: state 0=idle 1=run 2=done, strobes counted since last load, loaded tick count.
  int mState = 0, mK = 0, mL = 0;
  bit mPer = 0, mExpired = 0, mTimeout = 0;

  prog_timeout_timer #(.PRESCALE(P), .CNT_W(W)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cnt_en(cnt_en), .cnt_pulse(cnt_pulse),
    .load_val(load_val), .periodic(periodic), .restart(restart), .tick(tick),
    .timeout(timeout), .expired(expired), .busy(busy), .remaining(remaining));

  prog_timeout_timer #(.PRESCALE(1), .CNT_W(WB)) dutB (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cnt_en(enB), .cnt_pulse(pulseB),
    .load_val(loadB), .periodic(1'b0), .restart(1'b0), .tick(tickB),
    .timeout(timeoutB), .expired(expiredB), .busy(busyB), .remaining(remainingB));

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    int expRem;
    bit expTick;
    expRem  = (mState == 1) ? (mL - mK / P) : 0;
    expTick = (mState == 1) && cnt_pulse && ((mK % P) == P - 1);
    checkOutput("tick", 32'(tick), 32'(expTick));
    checkOutput("timeout", 32'(timeout), 32'(mTimeout));
    checkOutput("expired", 32'(expired), 32'(mExpired));
    checkOutput("busy", 32'(busy), 32'(mState == 1));
    checkOutput("remaining", 32'(remaining), 32'(expRem));
  endtask

  task automatic modelReset();
    mState = 0; mK = 0; mL = 0; mPer = 0; mExpired = 0; mTimeout = 0;
  endtask

  task automatic modelStep();
    int l;
    l = (load_val == 0) ? 1 : int'(load_val);
    mTimeout = 0;
    if (!cnt_en) begin
      modelReset();
    end else if (mState == 0) begin
      mState = 1; mK = 0; mL = l; mPer = periodic;
    end else if (mState == 1) begin
      if (restart) begin
        mK = 0; mL = l; mPer = periodic;
      end else if (cnt_pulse) begin
        if (mK + 1 == P * mL) begin
          mTimeout = 1;
          mK = 0;
          if (mPer) mL = l;
          else begin mState = 2; mExpired = 1; mL = 0; end
        end else begin
          mK++;
        end
      end
    end else if (restart) begin
      mState = 1; mK = 0; mL = l; mPer = periodic; mExpired = 0;
    end
  endtask

  task automatic applyStimulus(input bit en, input bit pulse, input int load,
                               input bit per, input bit rst);
    @(negedge sys_clk);
    cnt_en = en; cnt_pulse = pulse; load_val = W'(load); periodic = per; restart = rst;
    #1;
    checkAll();
    modelStep();
  endtask

  initial begin
    int pulses;

    #3;
    checkAll();
    checkOutput("rstB_busy", 32'(busyB), 32'd0);
    @(posedge sys_clk); #2 sys_rst_n = 1'b1;

    // One-shot, load 3, strobe every cycle.
    for (int i = 0; i < 18; i++) applyStimulus(1, 1, 3, 0, 0);

    // Periodic for 40 run cycles: expect three timeouts.
    applyStimulus(0, 0, 3, 0, 0);
    applyStimulus(1, 1, 3, 1, 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 1, 3, 1, 0);
      if (timeout) pulses++;
    end
    checkOutput("periodic_pulses", 32'(pulses), 32'd3);

    // Restart on the would-expire strobe, then restart from DONE.
    applyStimulus(0, 0, 3, 0, 0);
    applyStimulus(1, 1, 3, 0, 0);
    for (int i = 0; i < 11; i++) applyStimulus(1, 1, 3, 0, 0);
    applyStimulus(1, 1, 3, 0, 1);
    for (int i = 0; i < 16; i++) applyStimulus(1, 1, 3, 0, 0);
    applyStimulus(1, 1, 2, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 3, 0, 0);

    // Abort mid-count and on the exact expiry cycle.
    applyStimulus(0, 0, 3, 0, 0);
    applyStimulus(1, 1, 3, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 3, 0, 0);
    applyStimulus(0, 1, 3, 0, 0);
    applyStimulus(0, 1, 3, 0, 0);
    applyStimulus(1, 1, 3, 0, 0);
    for (int i = 0; i < 11; i++) applyStimulus(1, 1, 3, 0, 0);
    applyStimulus(0, 1, 3, 0, 0);
    applyStimulus(0, 0, 3, 0, 0);

    // A load of zero behaves as one tick.
    applyStimulus(1, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0, 0);

    // Asynchronous reset mid-run, then a fresh start after release.
    applyStimulus(0, 0, 5, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 5, 0, 0);
    #2 sys_rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(posedge sys_clk); #2 sys_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 5, 0, 0);

    // Random traffic.
    for (int i = 0; i < 2000; i++)
      applyStimulus($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0,
                    int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 31) == 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Full-range load with PRESCALE=1: expiry after exactly 15 strobes.
    @(negedge sys_clk);
    enB = 1'b1; pulseB = 1'b1; loadB = '1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge sys_clk); #1;
      checkOutput("B_remaining", 32'(remainingB), (i <= 15) ? 32'(16 - i) : 32'd0);
      checkOutput("B_tick", 32'(tickB), 32'(i <= 15));
      checkOutput("B_timeout", 32'(timeoutB), 32'(i == 16));
      checkOutput("B_busy", 32'(busyB), 32'(i <= 15));
      checkOutput("B_expired", 32'(expiredB), 32'(i >= 16));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_timeout_timer.md
# prog_timeout_timer

Parametrised successor to the fixed 1 µs base timer. It combines a programmable prescaler, which divides qualified `cnt_pulse` strobes into base ticks, with a loadable down-counter of base ticks. It supports one-shot and periodic modes, a watchdog-style restart, and sticky expiry status. The I2C controller uses it for SCL-low timeouts, bus-idle detection and retry back-off, replacing per-use hard-coded counters.

## Interface
- `PRESCALE`, default 50: qualified `cnt_pulse` strobes per base tick; legal range 1..255.
- `CNT_W`, default 16: width of the base-tick down-counter; legal range 2..24.
- `sys_clk` input 1: sole clock, rising edge.
- `sys_rst_n` input 1: one clock; reset is asynchronous and active-low.
- `cnt_en` input 1: timer enable. High starts or holds the timer; low aborts and clears everything.
- `cnt_pulse` input 1: count qualifier, one-cycle strobe from the system time base.
- `load_val` input CNT_W: number of base ticks to expiry. Sampled on start, restart and periodic reload.
- `periodic` input 1: 0 = one-shot, 1 = auto-reload. Sampled on start and restart only.
- `restart` input 1: synchronous kick while running; reloads both counters.
- `tick` output 1: one-cycle base-tick pulse (combinational, see Timing).
- `timeout` output 1: registered one-cycle expiry pulse.
- `expired` output 1: sticky expiry flag, one-shot mode only.
- `busy` output 1: high while in RUN.
- `remaining` output CNT_W: current down-counter value.

## Operation
- States: IDLE, RUN, DONE. State is held in registers; `busy` = (state == RUN).
- Any state, `cnt_en` = 0: go to IDLE next cycle. Clear `pre_cnt`, `remaining`, `expired` and the mode register. This overrides every other input.
- IDLE with `cnt_en` = 1: go to RUN. Set `remaining` = `load_val`, with a `load_val` of 0 treated as 1. Set `pre_cnt` = 0 and latch `periodic`.
- RUN, prescaler:
  - `pre_cnt` is `$clog2(PRESCALE)` bits wide, minimum 1.
  - It increments on `cnt_pulse`.
  - `tick` = RUN & `cnt_pulse` & (`pre_cnt` == PRESCALE-1). On a tick, `pre_cnt` wraps to 0.
  - A base tick is exactly PRESCALE strobes; there is no off-by-one extra state.
- RUN, down-counter: on `tick`, `remaining` decrements. Expiry is a tick while `remaining` == 1.
  - Periodic mode: reload `remaining` from `load_val` (0 treated as 1) and stay in RUN.
  - One-shot mode: set `remaining` to 0, set `expired` = 1 and go to DONE.
  - In both modes, `timeout` = 1 in the following cycle only.
- RUN with `restart` = 1: reload `remaining` and `pre_cnt` as on start and re-latch `periodic`. `restart` has priority over a coincident tick or expiry, so no `timeout` is generated.
- DONE: `remaining` = 0 and `expired` = 1 are held.
  - `cnt_pulse` is ignored.
  - `restart` = 1 re-arms the timer: go to RUN with a reload and clear `expired`.
  - `cnt_en` low clears the timer via IDLE.
- `restart` in IDLE is ignored.
- `remaining` never underflows; all arithmetic is unsigned and CNT_W bits wide.

## Timing
- Reset values: state = IDLE, `pre_cnt` = 0, `remaining` = 0, `timeout` = 0, `expired` = 0, `busy` = 0. `tick` = 0 because the state is IDLE.
- Start: `cnt_en` sampled high at edge N. From N+1, `busy` = 1 and `remaining` = `load_val`. Strobes are counted from the cycle after N.
- Expiry: `timeout` rises at the edge following the cycle carrying the (PRESCALE × L)-th counted strobe after start, where L = max(`load_val`, 1). It lasts one cycle. `expired` and `busy` = 0 (one-shot) change at the same edge.
- Periodic mode: consecutive `timeout` pulses are exactly PRESCALE × L counted strobes apart, with no strobe lost at the reload.
- Abort: `cnt_en` low at edge M forces all outputs to reset values from M+1, including a `timeout` that would have fired at M+1.
- `cnt_pulse` held high continuously is legal; each high cycle counts as one strobe.

## Test plan
- PRESCALE=4, `load_val`=3, one-shot, `cnt_pulse` every cycle: `tick` is seen on 3 cycles, and `timeout` is a single pulse 12 cycles after RUN entry. `expired` stays 1 and `busy` = 0 afterwards; `remaining` reads 3, 2, 1, 0.
- Same configuration with `periodic`=1, run for 40 cycles: `timeout` every 12 cycles, 3 pulses, `expired` stays 0.
- `restart` pulsed on the strobe that would expire: no `timeout`, and the next `timeout` follows 12 strobes later. `restart` in DONE re-arms the timer and clears `expired`.
- `cnt_en` dropped mid-count, and again on the exact expiry cycle: all outputs return to reset values the next cycle, with no `timeout`.
- `load_val`=0 behaves like 1, giving `timeout` after 4 strobes. `load_val` = 2^CNT_W−1 with PRESCALE=1 gives no wrap and expires after exactly that many strobes.
- Assert `sys_rst_n` asynchronously mid-RUN: outputs reach reset values without waiting for a clock edge. After release with `cnt_en` high, a fresh start occurs.
